mic_peak_meter: RTL and testbench
=================================

Name: mic_peak_meter

Overview:
Parametrised successor to the single-sample mic LED meter. It tracks the windowed peak of the 12-bit mic sample stream and quantises the peak into LEVELS linear bands with a sequential comparator, so no divider is needed. It drives an LED bar graph, plus an optional peak-hold marker that decays over time. It sits between the mic sampling block and the LED and seven-segment and OLED display logic.

Parameters:
SAMPLE_W, 12, mic sample width (unsigned).
LEVELS, 16, number of thresholds; level range 0..LEVELS; LED width = LEVELS.
BASE, 2200, first threshold T1 (silence floor).
STEP, 125, threshold spacing; Tk = BASE + (k-1)*STEP, k = 1..LEVELS.
WINDOW, 1024, clock cycles per peak window; must be > LEVELS+2.
HOLD_WIN, 4, windows the peak marker holds before it starts decaying.
LVL_W, $clog2(LEVELS+1), width of the level outputs (derived).

Ports:
clk_3p125mhz  in  1  system clock; all state updates on rising edge.
reset  in  1  asynchronous, active-high; clears all state.
en  in  1  when 0: window counter frozen and samples ignored; quantiser/update already in flight completes.
mode  in  1  0 = bar only; 1 = bar plus peak-hold marker.
mic  in  SAMPLE_W  unsigned mic sample, sampled every enabled cycle.
lvl  out  LVL_W  current level 0..LEVELS (registered).
peak_lvl  out  LVL_W  held peak level (registered).
led  out  LEVELS  bar graph (registered).
lvl_valid  out  1  one-cycle pulse when lvl/peak_lvl/led update.

Behaviour:
- Reset (async, any time, including mid-quantise): lvl=0, peak_lvl=0, led=0, lvl_valid=0, window count=0, running max=0, hold count=0, FSM=IDLE. Outputs stay 0 until the first full window completes after release.
- Window: on each enabled cycle, run_max <= max(run_max, mic) and win_cnt increments. On the cycle where win_cnt==WINDOW-1:
  - capture max(run_max, mic) into pk_cap;
  - clear run_max to 0 and win_cnt to 0;
  - start the quantiser.
  - The next window accumulates concurrently with quantisation.
- Quantiser FSM IDLE -> QUANT -> UPDATE -> IDLE:
  - QUANT runs exactly LEVELS cycles; on cycle k it compares pk_cap > Tk and increments the count if true. Thresholds are generated incrementally by an adder (thr += STEP), at SAMPLE_W+1 bits to avoid wrap.
  - Result: level = number of Tk strictly below the peak. Peak <= BASE gives 0; peak > T_LEVELS gives LEVELS.
- UPDATE (one cycle) registers lvl=level and the peak logic, and pulses lvl_valid.
- Fixed latency: lvl_valid is asserted LEVELS+2 cycles after the window-end edge.
- Peak hold (evaluated in UPDATE):
  - if level >= peak_lvl: peak_lvl <= level, hold_cnt <= HOLD_WIN;
  - else if hold_cnt != 0: hold_cnt decrements;
  - else peak_lvl <= max(peak_lvl-1, level).
- LED: led[i]=1 iff i < lvl. If mode=1 and peak_lvl>0, led[peak_lvl-1] is also 1. The mode change takes effect at the next UPDATE.
- A window end cannot occur while the FSM is busy, guaranteed by WINDOW > LEVELS+2. This is checked by an elaboration-time assertion.
- If en falls during QUANT, quantisation and UPDATE still complete. run_max and win_cnt are held.

Decomposition:
- definitions.vh gains:
  - `MIC_W 12;
  - `MIC_BASE 2200;
  - `MIC_STEP 125;
  - `MIC_LEVELS 16;
  - FSM state encodings `MPM_IDLE/`MPM_QUANT/`MPM_UPDATE.
  - The existing `LDBIT stays and must equal LEVELS-1 at the top level.
- One sub-module: mic_level_quantizer. It holds the threshold adder, the comparator, the cycle and level counters, and emits done plus level. The window max, peak-hold and LED mapping stay in mic_peak_meter.

Test Plan:
All scenarios use WINDOW=32, LEVELS=16, BASE=2200, STEP=125, HOLD_WIN=2, mode=0 unless stated.
1. Constant mic=2048 for 3 windows -> lvl=0, led=16'h0000, one lvl_valid per window exactly 18 cycles after each window end.
2. Boundary sweep: window peak 2200 -> lvl 0; 2201 -> 1 (led 16'h0001); 2326 -> 2 (led 16'h0003); 4075 -> 15 (led 16'h7FFF); 4095 -> 16 (led 16'hFFFF).
3. Single-cycle spike 3300 in a window of 2100s -> lvl=9, led=16'h01FF (max captured, not last sample). The next window of 2100s -> lvl=0.
4. mode=1: one window with peak 3300 (lvl 9), then windows of 2100. Expected peak_lvl = 9, 9, 9, then 8, 7, ..., 0 one step per window; led = 16'h0100 while the marker is held at 9.
5. en=0 for 100 cycles mid-window with mic=4095 -> the spike is ignored, lvl_valid timing shifts by exactly 100 cycles, and there is no level change.
6. reset pulsed during QUANT of a 4095 window -> all outputs 0 immediately (asynchronous clear). No lvl_valid occurs for the aborted window, and the first pulse after release comes 32+18 cycles later.

Source files
------------

// File: rtl/mic_peak_meter_pkg.sv
// -----------------------------------------------------------------------------
// mic_peak_meter_pkg
// Shared constants for the mic peak meter slice: default mic sample format,
// default level-threshold ladder, the LED bar MSB index used by the existing
// display logic, and the quantiser FSM state encodings.
// No ports (package).
// -----------------------------------------------------------------------------
package mic_peak_meter_pkg;

    // Default mic sample width and threshold ladder (T1 = silence floor).
    localparam int MIC_W      = 12;
    localparam int MIC_BASE   = 2200;
    localparam int MIC_STEP   = 125;
    localparam int MIC_LEVELS = 16;

    // MSB index of the LED bar as seen by the downstream display blocks.
    localparam int LDBIT = 15;

    // Quantiser FSM state encodings.
    localparam logic [1:0] MPM_IDLE   = 2'd0;
    localparam logic [1:0] MPM_QUANT  = 2'd1;
    localparam logic [1:0] MPM_UPDATE = 2'd2;

endpackage

// File: rtl/mic_level_quantizer.sv
// -----------------------------------------------------------------------------
// mic_level_quantizer
// Sequential threshold comparator: after a start pulse it walks the threshold
// ladder Tk = BASE + (k-1)*STEP for k = 1..LEVELS, one threshold per cycle,
// and counts how many thresholds lie strictly below the captured peak.
//
// Ports:
//   clk_3p125mhz  in   system clock
//   reset         in   asynchronous active-high clear
//   start         in   load the ladder; comparisons run on the next LEVELS edges
//   peak          in   captured window peak, held stable while busy
//   done          out  one-cycle pulse when level is final
//   level         out  number of thresholds strictly below peak (0..LEVELS)
// -----------------------------------------------------------------------------
module mic_level_quantizer
    import mic_peak_meter_pkg::*;
#(
    parameter int SAMPLE_W = MIC_W,
    parameter int LEVELS   = MIC_LEVELS,
    parameter int BASE     = MIC_BASE,
    parameter int STEP     = MIC_STEP,
    parameter int LVL_W    = $clog2(LEVELS + 1)
) (
    input  logic                clk_3p125mhz,
    input  logic                reset,
    input  logic                start,
    input  logic [SAMPLE_W-1:0] peak,
    output logic                done,
    output logic [LVL_W-1:0]    level
);

    // One extra bit so the running threshold never wraps past the top sample.
    localparam int THR_W = SAMPLE_W + 1;

    localparam logic [THR_W-1:0] BASE_C   = THR_W'(BASE);
    localparam logic [THR_W-1:0] STEP_C   = THR_W'(STEP);
    localparam logic [THR_W-1:0] THR_ZERO = THR_W'(0);
    localparam logic [LVL_W-1:0] LVL_ZERO = LVL_W'(0);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LAST_CYC = LVL_W'(LEVELS - 1);

    logic [THR_W-1:0] thr_r;
    logic [LVL_W-1:0] cnt_r;
    logic [LVL_W-1:0] cyc_r;
    logic             busy_r;
    logic             done_r;
    logic             above_s;

    assign above_s = ({1'b0, peak} > thr_r);

    // Threshold walk: compare, count, advance threshold; flag done on last step.
    always_ff @(posedge clk_3p125mhz or posedge reset) begin
        if (reset) begin
            thr_r  <= THR_ZERO;
            cnt_r  <= LVL_ZERO;
            cyc_r  <= LVL_ZERO;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (start) begin
            thr_r  <= BASE_C;
            cnt_r  <= LVL_ZERO;
            cyc_r  <= LVL_ZERO;
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else if (busy_r) begin
            thr_r <= thr_r + STEP_C;
            if (above_s) begin
                cnt_r <= cnt_r + LVL_ONE;
            end
            if (cyc_r == LAST_CYC) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end else begin
                cyc_r <= cyc_r + LVL_ONE;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign done  = done_r;
    assign level = cnt_r;

endmodule

// File: rtl/mic_peak_meter.sv
// -----------------------------------------------------------------------------
// mic_peak_meter
// Windowed peak meter for the 12-bit mic stream. Tracks the maximum sample of
// each WINDOW-cycle window, quantises it into LEVELS linear bands through
// mic_level_quantizer, and drives an LED bar with an optional decaying
// peak-hold marker.
//
// Ports:
//   clk_3p125mhz  in   system clock
//   reset         in   asynchronous active-high clear of all state
//   en            in   0 freezes window counter and running max
//   mode          in   0 = bar only, 1 = bar plus peak-hold marker
//   mic           in   unsigned mic sample
//   lvl           out  current level 0..LEVELS (registered)
//   peak_lvl      out  held peak level (registered)
//   led           out  bar graph, led[i] = 1 iff i < lvl, plus marker
//   lvl_valid     out  one-cycle pulse when lvl/peak_lvl/led update
// -----------------------------------------------------------------------------
module mic_peak_meter
    import mic_peak_meter_pkg::*;
#(
    parameter int SAMPLE_W = MIC_W,
    parameter int LEVELS   = MIC_LEVELS,
    parameter int BASE     = MIC_BASE,
    parameter int STEP     = MIC_STEP,
    parameter int WINDOW   = 1024,
    parameter int HOLD_WIN = 4,
    parameter int LVL_W    = $clog2(LEVELS + 1)
) (
    input  logic                clk_3p125mhz,
    input  logic                reset,
    input  logic                en,
    input  logic                mode,
    input  logic [SAMPLE_W-1:0] mic,
    output logic [LVL_W-1:0]    lvl,
    output logic [LVL_W-1:0]    peak_lvl,
    output logic [LEVELS-1:0]   led,
    output logic                lvl_valid
);

    localparam int WIN_W  = $clog2(WINDOW);
    localparam int HOLD_W = $clog2(HOLD_WIN + 2);

    localparam logic [WIN_W-1:0]    WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [WIN_W-1:0]    WIN_ZERO  = WIN_W'(0);
    localparam logic [WIN_W-1:0]    WIN_ONE   = WIN_W'(1);
    localparam logic [HOLD_W-1:0]   HOLD_LOAD = HOLD_W'(HOLD_WIN);
    localparam logic [HOLD_W-1:0]   HOLD_ZERO = HOLD_W'(0);
    localparam logic [HOLD_W-1:0]   HOLD_ONE  = HOLD_W'(1);
    localparam logic [LVL_W-1:0]    LVL_ZERO  = LVL_W'(0);
    localparam logic [LVL_W-1:0]    LVL_ONE   = LVL_W'(1);
    localparam logic [SAMPLE_W-1:0] SMP_ZERO  = SAMPLE_W'(0);
    localparam logic [LEVELS-1:0]   LED_ZERO  = LEVELS'(0);

    // The quantiser must be idle again before the next window can end, and
    // the LED bar width must match the display blocks' MSB index.
    generate
        if (WINDOW <= LEVELS + 2) begin : g_window_too_short
            $error("mic_peak_meter: WINDOW must exceed LEVELS+2");
        end
        if (LDBIT != LEVELS - 1) begin : g_ldbit_mismatch
            $error("mic_peak_meter: LDBIT must equal LEVELS-1");
        end
    endgenerate

    logic [WIN_W-1:0]    win_cnt_r;
    logic [SAMPLE_W-1:0] run_max_r;
    logic [SAMPLE_W-1:0] pk_cap_r;
    logic [1:0]          state_r;
    logic [1:0]          state_nxt_s;
    logic [LVL_W-1:0]    lvl_r;
    logic [LVL_W-1:0]    peak_lvl_r;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic [LEVELS-1:0]   led_r;
    logic                lvl_valid_r;

    logic                win_end_s;
    logic [SAMPLE_W-1:0] max_s;
    logic                q_done_s;
    logic [LVL_W-1:0]    q_level_s;
    logic [LVL_W-1:0]    pk_nxt_s;
    logic [HOLD_W-1:0]   hold_nxt_s;
    logic [LVL_W-1:0]    pk_dec_s;
    logic [LEVELS-1:0]   led_nxt_s;

    assign win_end_s = en && (win_cnt_r == WIN_LAST);
    // The sample on the window-end cycle still belongs to the closing window.
    assign max_s     = (mic > run_max_r) ? mic : run_max_r;

    // Window accumulation: running max and cycle count, frozen while en=0.
    always_ff @(posedge clk_3p125mhz or posedge reset) begin
        if (reset) begin
            win_cnt_r <= WIN_ZERO;
            run_max_r <= SMP_ZERO;
            pk_cap_r  <= SMP_ZERO;
        end else if (win_end_s) begin
            pk_cap_r  <= max_s;
            run_max_r <= SMP_ZERO;
            win_cnt_r <= WIN_ZERO;
        end else if (en) begin
            run_max_r <= max_s;
            win_cnt_r <= win_cnt_r + WIN_ONE;
        end else begin
            run_max_r <= run_max_r;
            win_cnt_r <= win_cnt_r;
        end
    end

    mic_level_quantizer #(
        .SAMPLE_W (SAMPLE_W),
        .LEVELS   (LEVELS),
        .BASE     (BASE),
        .STEP     (STEP),
        .LVL_W    (LVL_W)
    ) u_quant (
        .clk_3p125mhz (clk_3p125mhz),
        .reset        (reset),
        .start        (win_end_s),
        .peak         (pk_cap_r),
        .done         (q_done_s),
        .level        (q_level_s)
    );

    // FSM next state: IDLE -> QUANT on window end, QUANT -> UPDATE on done.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            MPM_IDLE: begin
                if (win_end_s) begin
                    state_nxt_s = MPM_QUANT;
                end else begin
                    state_nxt_s = MPM_IDLE;
                end
            end
            MPM_QUANT: begin
                if (q_done_s) begin
                    state_nxt_s = MPM_UPDATE;
                end else begin
                    state_nxt_s = MPM_QUANT;
                end
            end
            MPM_UPDATE: state_nxt_s = MPM_IDLE;
            default:    state_nxt_s = MPM_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_3p125mhz or posedge reset) begin
        if (reset) begin
            state_r <= MPM_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Peak-hold decision: follow rises at once, hold HOLD_WIN windows, then
    // decay one level per window without dropping below the new level.
    always_comb begin
        pk_nxt_s   = peak_lvl_r;
        hold_nxt_s = hold_cnt_r;
        pk_dec_s   = peak_lvl_r - LVL_ONE;
        if (q_level_s >= peak_lvl_r) begin
            pk_nxt_s   = q_level_s;
            hold_nxt_s = HOLD_LOAD;
        end else if (hold_cnt_r != HOLD_ZERO) begin
            pk_nxt_s   = peak_lvl_r;
            hold_nxt_s = hold_cnt_r - HOLD_ONE;
        end else begin
            pk_nxt_s   = (pk_dec_s > q_level_s) ? pk_dec_s : q_level_s;
            hold_nxt_s = HOLD_ZERO;
        end
    end

    // LED map: thermometer bar below the level, plus the marker bit in mode 1.
    always_comb begin
        led_nxt_s = LED_ZERO;
        for (int i = 0; i < LEVELS; i++) begin
            led_nxt_s[i] = (LVL_W'(i) < q_level_s) ||
                           (mode && (pk_nxt_s == LVL_W'(i + 1)));
        end
    end

    // Output registers, loaded only in UPDATE together with the valid pulse.
    always_ff @(posedge clk_3p125mhz or posedge reset) begin
        if (reset) begin
            lvl_r       <= LVL_ZERO;
            peak_lvl_r  <= LVL_ZERO;
            hold_cnt_r  <= HOLD_ZERO;
            led_r       <= LED_ZERO;
            lvl_valid_r <= 1'b0;
        end else if (state_r == MPM_UPDATE) begin
            lvl_r       <= q_level_s;
            peak_lvl_r  <= pk_nxt_s;
            hold_cnt_r  <= hold_nxt_s;
            led_r       <= led_nxt_s;
            lvl_valid_r <= 1'b1;
        end else begin
            lvl_valid_r <= 1'b0;
        end
    end

    assign lvl       = lvl_r;
    assign peak_lvl  = peak_lvl_r;
    assign led       = led_r;
    assign lvl_valid = lvl_valid_r;

endmodule

// File: tb/tb_mic_peak_meter.sv
// -----------------------------------------------------------------------------
// tb_mic_peak_meter
// Directed bench for mic_peak_meter (WINDOW=32, LEVELS=16, HOLD_WIN=2).
// Each window is driven sample by sample; its hand-computed result and the
// cycle at which lvl_valid must appear are queued, and a negedge monitor
// matches every lvl_valid pulse against the queue.
// -----------------------------------------------------------------------------
module tb_mic_peak_meter;

    logic        clk_3p125mhz = 1'b0;
    logic        reset;
    logic        en;
    logic        mode;
    logic [11:0] mic;
    logic [4:0]  lvl;
    logic [4:0]  peak_lvl;
    logic [15:0] led;
    logic        lvl_valid;

    int cyc    = 0;
    int n_vec  = 0;
    int n_err  = 0;

    typedef struct {
        int          at;
        logic [4:0]  lvl;
        logic [4:0]  pk;
        logic [15:0] led;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    mic_peak_meter #(
        .SAMPLE_W (12),
        .LEVELS   (16),
        .BASE     (2200),
        .STEP     (125),
        .WINDOW   (32),
        .HOLD_WIN (2)
    ) dut (
        .clk_3p125mhz (clk_3p125mhz),
        .reset        (reset),
        .en           (en),
        .mode         (mode),
        .mic          (mic),
        .lvl          (lvl),
        .peak_lvl     (peak_lvl),
        .led          (led),
        .lvl_valid    (lvl_valid)
    );

    always #5 clk_3p125mhz = ~clk_3p125mhz;

    always @(posedge clk_3p125mhz) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drives one full window of enabled samples; optionally a single spike
    // and an en=0 gap (mic=4095 during the gap). Queues the expected result.
    task automatic run_window(input logic [11:0] fill, input int spike_at,
                              input logic [11:0] spike_val, input int gap_at,
                              input int gap_len, input bit expect_out,
                              input logic [4:0] e_lvl, input logic [4:0] e_pk,
                              input logic [15:0] e_led);
        exp_t e;
        for (int i = 0; i < 32; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    en  = 1'b0;
                    mic = 12'd4095;
                    @(posedge clk_3p125mhz); #1;
                end
            end
            en  = 1'b1;
            mic = (i == spike_at) ? spike_val : fill;
            @(posedge clk_3p125mhz); #1;
        end
        if (expect_out) begin
            e.at  = cyc + 18;
            e.lvl = e_lvl;
            e.pk  = e_pk;
            e.led = e_led;
            exp_q.push_back(e);
        end
    endtask

    // Matches each lvl_valid pulse with the oldest queued window result.
    always @(negedge clk_3p125mhz) begin
        if (!reset) begin
            if (lvl_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 32'(lvl_valid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("valid_cycle", 32'(cyc), 32'(mon_e.at));
                    check("lvl", 32'(lvl), 32'(mon_e.lvl));
                    check("peak_lvl", 32'(peak_lvl), 32'(mon_e.pk));
                    check("led", 32'(led), 32'(mon_e.led));
                end
            end else if (exp_q.size() != 0 && cyc > exp_q[0].at) begin
                check("valid_missing", 32'(lvl_valid), 32'd1);
                exp_q.delete(0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [4:0]  pk;
        logic [15:0] ld;

        reset = 1'b1;
        en    = 1'b0;
        mode  = 1'b0;
        mic   = 12'd0;
        repeat (3) @(posedge clk_3p125mhz);
        #1;
        check("rst_lvl", 32'(lvl), 32'd0);
        check("rst_peak", 32'(peak_lvl), 32'd0);
        check("rst_led", 32'(led), 32'd0);
        check("rst_valid", 32'(lvl_valid), 32'd0);
        reset = 1'b0;

        // Silence below the floor.
        repeat (3) run_window(12'd2048, -1, 12'd0, -1, 0, 1'b1, 5'd0, 5'd0, 16'h0000);

        // Threshold boundaries.
        run_window(12'd2200, -1, 12'd0, -1, 0, 1'b1, 5'd0,  5'd0,  16'h0000);
        run_window(12'd2201, -1, 12'd0, -1, 0, 1'b1, 5'd1,  5'd1,  16'h0001);
        run_window(12'd2326, -1, 12'd0, -1, 0, 1'b1, 5'd2,  5'd2,  16'h0003);
        run_window(12'd4075, -1, 12'd0, -1, 0, 1'b1, 5'd15, 5'd15, 16'h7FFF);
        run_window(12'd4095, -1, 12'd0, -1, 0, 1'b1, 5'd16, 5'd16, 16'hFFFF);

        // Mid-window spike; peak 16 held for two windows.
        run_window(12'd2100, 10, 12'd3300, -1, 0, 1'b1, 5'd9, 5'd16, 16'h01FF);
        run_window(12'd2100, -1, 12'd0,    -1, 0, 1'b1, 5'd0, 5'd16, 16'h0000);

        // Spike on the window-end sample; hold expired so peak decays to 15.
        run_window(12'd2100, 31, 12'd3300, -1, 0, 1'b1, 5'd9, 5'd15, 16'h01FF);

        // Full-scale window aborted by reset while it is being quantised.
        run_window(12'd4095, -1, 12'd0, -1, 0, 1'b0, 5'd0, 5'd0, 16'h0000);
        en  = 1'b1;
        mic = 12'd2100;
        repeat (5) @(posedge clk_3p125mhz);
        #3;
        reset = 1'b1;
        #1;
        check("arst_lvl", 32'(lvl), 32'd0);
        check("arst_peak", 32'(peak_lvl), 32'd0);
        check("arst_led", 32'(led), 32'd0);
        check("arst_valid", 32'(lvl_valid), 32'd0);
        exp_q.delete();
        en = 1'b0;
        repeat (2) @(posedge clk_3p125mhz);
        #1;
        reset = 1'b0;

        // Peak-hold marker: 9 held for HOLD_WIN windows, then one step down each.
        mode = 1'b1;
        run_window(12'd2100, 5, 12'd3300, -1, 0, 1'b1, 5'd9, 5'd9, 16'h01FF);
        for (int n = 2; n <= 12; n++) begin
            pk = (n <= 3) ? 5'd9 : 5'(12 - n);
            ld = (pk == 5'd0) ? 16'h0000 : (16'h0001 << (pk - 5'd1));
            run_window(12'd2100, -1, 12'd0, -1, 0, 1'b1, 5'd0, pk, ld);
        end
        mode = 1'b0;

        // en=0 for 100 cycles mid-window with full-scale mic: ignored, late by 100.
        run_window(12'd2100, -1, 12'd0, 16, 100, 1'b1, 5'd0, 5'd0, 16'h0000);

        en  = 1'b0;
        mic = 12'd0;
        repeat (40) @(posedge clk_3p125mhz);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
